// File: rtl/jtag_reg_bank.sv
// User data-register bank behind a JTAG user instruction: per-register or daisy-chained
// shift path on DRCK, parallel outputs, commit strobes and a sticky error flag on TCK.
module jtag_reg_bank #(
  parameter int                    NREG      = 4,
  parameter int                    WIDTH     = 16,
  parameter logic [NREG*WIDTH-1:0] DEF_VALUE = '0,
  parameter bit                    RDBK_SRC  = 1'b0,
  parameter bit                    STRICT    = 1'b1
) (
  input  logic                  TCK,
  input  logic                  RST,
  input  logic                  DRCK,
  input  logic                  SEL,
  input  logic [NREG-1:0]       FSEL,
  input  logic                  TDI,
  input  logic                  CAPTURE,
  input  logic                  SHIFT,
  input  logic                  UPDATE,
  input  logic                  DSY_CHAIN,
  input  logic [NREG*WIDTH-1:0] RDBK,
  output logic [NREG*WIDTH-1:0] PO,
  output logic [NREG-1:0]       UPD_STB,
  output logic                  TDO,
  output logic                  ERR
);

  localparam int TOT = NREG * WIDTH;
  localparam int CW  = $clog2(TOT + 2);
  localparam logic [CW-1:0] LEN_SINGLE = CW'(WIDTH);
  localparam logic [CW-1:0] LEN_CHAIN  = CW'(TOT);

  logic [TOT-1:0]  sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TOT-1:0]  po_q, po_d;
  logic [NREG-1:0] upd_stb_q, upd_stb_d;
  logic            err_q, err_d;
  logic            upd_q, upd_d;

  logic            one_hot;
  logic            illegal;
  logic [NREG-1:0] act;
  logic [CW-1:0]   len;
  logic            upd_rise;
  logic            commit;
  logic            tdo_bit;

  assign one_hot  = (FSEL != '0) && ((FSEL & (FSEL - NREG'(1))) == '0);
  assign illegal  = !DSY_CHAIN && !one_hot;
  assign act      = DSY_CHAIN ? {NREG{1'b1}} : FSEL;
  assign len      = DSY_CHAIN ? LEN_CHAIN : LEN_SINGLE;
  assign upd_rise = UPDATE && !upd_q;
  assign commit   = SEL && upd_rise && !illegal && (!STRICT || (cnt_q == len));

  // Shift stage (DRCK domain); CAPTURE wins over SHIFT when both are high.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (SEL && !illegal) begin
      if (CAPTURE) begin
        for (int k = 0; k < NREG; k++) begin
          if (act[k]) begin
            sr_d[k*WIDTH +: WIDTH] = RDBK_SRC ? RDBK[k*WIDTH +: WIDTH] : po_q[k*WIDTH +: WIDTH];
          end
        end
        cnt_d = '0;
      end else if (SHIFT) begin
        if (DSY_CHAIN) begin
          sr_d = {TDI, sr_q[TOT-1:1]};
        end else begin
          for (int k = 0; k < NREG; k++) begin
            if (FSEL[k]) begin
              sr_d[k*WIDTH +: WIDTH] = {TDI, sr_q[k*WIDTH+1 +: WIDTH-1]};
            end
          end
        end
        if (cnt_q < len + CW'(1)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge DRCK or posedge RST) begin
    if (RST) begin
      sr_q  <= DEF_VALUE;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    tdo_bit = 1'b0;
    if (SEL && !illegal) begin
      if (DSY_CHAIN) begin
        tdo_bit = sr_q[0];
      end else begin
        for (int k = 0; k < NREG; k++) begin
          if (FSEL[k]) begin
            tdo_bit = sr_q[k*WIDTH];
          end
        end
      end
    end
  end

  // Parallel/status stage (TCK domain). The counter is stable here because DRCK
  // is gated off while the TAP sits in Update-DR.
  always_comb begin
    po_d      = po_q;
    upd_stb_d = '0;
    err_d     = err_q;
    upd_d     = UPDATE;
    if (commit) begin
      for (int k = 0; k < NREG; k++) begin
        if (act[k]) begin
          po_d[k*WIDTH +: WIDTH] = sr_q[k*WIDTH +: WIDTH];
        end
      end
      upd_stb_d = act;
    end
    if (SEL && upd_rise && !illegal && !commit) begin
      err_d = 1'b1;
    end
    if (SEL && illegal && (CAPTURE || SHIFT || UPDATE)) begin
      err_d = 1'b1;
    end
    if (SEL && CAPTURE && DSY_CHAIN && (FSEL == '0)) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      po_q      <= DEF_VALUE;
      upd_stb_q <= '0;
      err_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      po_q      <= po_d;
      upd_stb_q <= upd_stb_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
    end
  end

  assign PO      = po_q;
  assign UPD_STB = upd_stb_q;
  assign TDO     = tdo_bit;
  assign ERR     = err_q;

endmodule

// File: tb/tb_jtag_reg_bank.sv
// Directed bench for jtag_reg_bank: one instance capturing from PO, one from RDBK.
module tb_jtag_reg_bank;
  localparam logic [63:0] DEF = 64'h4444_3333_2222_1111;

  logic        tck = 1'b0;
  logic        rst = 1'b1;
  logic        drck_en = 1'b0;
  logic        drck;
  logic        sel = 1'b0;
  logic [3:0]  fsel = 4'b0000;
  logic        tdi = 1'b0;
  logic        capture = 1'b0;
  logic        shift = 1'b0;
  logic        update = 1'b0;
  logic        dsy = 1'b0;
  logic [63:0] rdbk = 64'h0000_BEEF_0000_0000;

  logic [63:0] po, po_rb;
  logic [3:0]  upd_stb, stb_rb;
  logic        tdo, tdo_rb, err, err_rb;

  int n_chk = 0;
  int n_err = 0;

  assign drck = tck & drck_en;
  always #5 tck = ~tck;

  jtag_reg_bank #(.NREG(4), .WIDTH(16), .DEF_VALUE(DEF), .RDBK_SRC(1'b0), .STRICT(1'b1)) u_dut (
    .TCK(tck), .RST(rst), .DRCK(drck), .SEL(sel), .FSEL(fsel), .TDI(tdi),
    .CAPTURE(capture), .SHIFT(shift), .UPDATE(update), .DSY_CHAIN(dsy), .RDBK(rdbk),
    .PO(po), .UPD_STB(upd_stb), .TDO(tdo), .ERR(err)
  );

  jtag_reg_bank #(.NREG(4), .WIDTH(16), .RDBK_SRC(1'b1), .STRICT(1'b1)) u_rb (
    .TCK(tck), .RST(rst), .DRCK(drck), .SEL(sel), .FSEL(fsel), .TDI(tdi),
    .CAPTURE(capture), .SHIFT(shift), .UPDATE(update), .DSY_CHAIN(dsy), .RDBK(rdbk),
    .PO(po_rb), .UPD_STB(stb_rb), .TDO(tdo_rb), .ERR(err_rb)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_capture();
    @(negedge tck);
    capture = 1'b1;
    drck_en = 1'b1;
    @(negedge tck);
    capture = 1'b0;
    drck_en = 1'b0;
  endtask

  task automatic do_shift(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge tck);
      shift   = 1'b1;
      tdi     = v[i];
      drck_en = 1'b1;
    end
    @(negedge tck);
    shift   = 1'b0;
    drck_en = 1'b0;
    tdi     = 1'b0;
  endtask

  // UPDATE is held for two TCK cycles: strobe must appear once, then drop.
  task automatic do_update(input logic [3:0] exp_stb, input string tag);
    @(negedge tck);
    update = 1'b1;
    @(negedge tck);
    chk({tag, "_stb"}, 64'(upd_stb), 64'(exp_stb));
    @(negedge tck);
    chk({tag, "_stb_hold"}, 64'(upd_stb), 64'h0);
    update = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_rb;
    logic [15:0] pat;
    exp_rb = 16'hBEEF;
    pat    = 16'h3C5A;

    repeat (2) @(negedge tck);
    rst = 1'b0;
    chk("rst_po", po, DEF);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_stb", 64'(upd_stb), 64'h0);
    chk("rst_tdo", 64'(tdo), 64'h0);

    // single register write
    sel  = 1'b1;
    fsel = 4'b0010;
    do_capture();
    do_shift(64'hA5C3, 16);
    do_update(4'b0010, "single");
    chk("single_po", po, 64'h4444_3333_A5C3_1111);
    chk("single_err", 64'(err), 64'h0);

    // daisy chain write
    dsy  = 1'b1;
    fsel = 4'b0000;
    do_capture();
    do_shift(64'h0123_4567_89AB_CDEF, 64);
    do_update(4'b1111, "chain");
    chk("chain_po", po, 64'h0123_4567_89AB_CDEF);

    // short shift under strict counting
    dsy  = 1'b0;
    fsel = 4'b0001;
    do_capture();
    do_shift(64'hFFFF, 15);
    do_update(4'b0000, "short");
    chk("short_po", po, 64'h0123_4567_89AB_CDEF);
    chk("short_err", 64'(err), 64'h1);
    dsy  = 1'b1;
    fsel = 4'b0000;
    do_capture();
    chk("clr_err1", 64'(err), 64'h0);

    // long shift: counter saturates past the exact length
    dsy  = 1'b0;
    fsel = 4'b0001;
    do_capture();
    do_shift(64'h1_FFFF, 17);
    do_update(4'b0000, "long");
    chk("long_po", po, 64'h0123_4567_89AB_CDEF);
    chk("long_err", 64'(err), 64'h1);
    dsy  = 1'b1;
    fsel = 4'b0000;
    do_capture();
    chk("clr_err2", 64'(err), 64'h0);

    // readback capture serialised on TDO
    dsy  = 1'b0;
    fsel = 4'b0100;
    do_capture();
    for (int i = 0; i < 16; i++) begin
      @(negedge tck);
      chk($sformatf("rdbk_tdo%0d", i), 64'(tdo_rb), 64'(exp_rb[i]));
      shift   = 1'b1;
      tdi     = pat[i];
      drck_en = 1'b1;
    end
    @(negedge tck);
    shift   = 1'b0;
    drck_en = 1'b0;

    // illegal select during shift leaves shift data and count alone
    fsel = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(negedge tck);
      chk("ill_tdo", 64'(tdo), 64'h0);
      shift   = 1'b1;
      tdi     = 1'b1;
      drck_en = 1'b1;
    end
    @(negedge tck);
    shift   = 1'b0;
    drck_en = 1'b0;
    chk("ill_err", 64'(err), 64'h1);
    fsel = 4'b0100;
    do_update(4'b0100, "after_ill");
    chk("after_ill_po", po, 64'h0123_3C5A_89AB_CDEF);

    // reset mid-shift
    fsel = 4'b0001;
    do_capture();
    for (int i = 0; i < 5; i++) begin
      @(negedge tck);
      shift   = 1'b1;
      tdi     = 1'b1;
      drck_en = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_po", po, DEF);
    chk("rst_mid_err", 64'(err), 64'h0);
    @(negedge tck);
    rst     = 1'b0;
    shift   = 1'b0;
    drck_en = 1'b0;
    do_update(4'b0000, "post_rst");
    chk("post_rst_po", po, DEF);
    chk("post_rst_err", 64'(err), 64'h1);

    // deselected: TDO low, no commit, state frozen
    sel = 1'b0;
    @(negedge tck);
    chk("nosel_tdo", 64'(tdo), 64'h0);
    do_update(4'b0000, "nosel");
    chk("nosel_po", po, DEF);
    chk("nosel_err", 64'(err), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/jtag_reg_bank.md
JTAG_REG_BANK -- requirements
Module: jtag_reg_bank

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREG, 4, number of user registers (1..16).
- WIDTH, 16, bits per register (2..64).
- DEF_VALUE, all-zero, reset value of the register bank (NREG*WIDTH bits); register k occupies bits [k*WIDTH +: WIDTH].
- RDBK_SRC, 0, capture source: 0 = own PO slice, 1 = RDBK slice.
- STRICT, 1, 1 = UPDATE commits only on an exact shift count; 0 = always commit.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- TCK, in, 1, JTAG clock; clocks the parallel and status registers.
- RST, in, 1, reset, asynchronous, active-high.
- DRCK, in, 1, data-register clock (gated TCK); clocks the shift stage and the shift counter.
- SEL, in, 1, user instruction active.
- FSEL, in, NREG, one-hot register select.
- TDI, in, 1, serial data in.
- CAPTURE, in, 1, Capture-DR state.
- SHIFT, in, 1, Shift-DR state.
- UPDATE, in, 1, Update-DR state.
- DSY_CHAIN, in, 1, chain all registers into one NREG*WIDTH shift path.
- RDBK, in, NREG*WIDTH, status readback inputs.
- PO, out, NREG*WIDTH, parallel outputs.
- UPD_STB, out, NREG, one-TCK commit strobe per register.
- TDO, out, 1, serial data out.
- ERR, out, 1, sticky error flag.

Function
REQ-003 Active set SHALL be FSEL when DSY_CHAIN=0, all registers when DSY_CHAIN=1; the active set is "illegal" when DSY_CHAIN=0 and popcount(FSEL) != 1.
REQ-004 On DRCK rising edge with SEL=1, CAPTURE=1 and a legal active set, each active shift register SHALL load its capture source (RDBK_SRC), and the shift counter SHALL clear to 0.
REQ-005 On DRCK rising edge with SEL=1, SHIFT=1 and a legal active set, shifting SHALL be right-shift, LSB out: single mode shifts TDI into the MSB of the selected register; chain mode shifts TDI into the MSB of register NREG-1, bit 0 of register k into the MSB of register k-1.
REQ-006 The shift counter SHALL increment on every shift edge and saturate at L+1, where L = WIDTH (single mode) or NREG*WIDTH (chain mode).
REQ-007 TDO SHALL be bit 0 of the selected register (single mode) or bit 0 of register 0 (chain mode), and 0 when SEL=0 or the active set is illegal.
REQ-008 On TCK rising edge with SEL=1 and UPDATE=1: if STRICT=0 or counter==L, every active PO slice SHALL load its shift register and the matching UPD_STB bit SHALL be 1 for exactly that next TCK cycle; otherwise PO SHALL hold and ERR SHALL set.
REQ-009 An illegal active set during CAPTURE, SHIFT or UPDATE SHALL set ERR and SHALL leave every shift register, PO, and the counter unchanged.
REQ-010 ERR SHALL clear only on RST or on a CAPTURE edge in which SEL=1, DSY_CHAIN=1 and FSEL is all zeros.
REQ-011 UPDATE held high for N TCK cycles SHALL produce at most one UPD_STB pulse per register; the UPDATE rising edge is detected in the TCK domain.
REQ-012 Inactive registers SHALL hold their shift and PO contents at all times; SEL=0 SHALL freeze all state except UPD_STB, which returns to 0.
REQ-013 CAPTURE and SHIFT both high SHALL be treated as CAPTURE.

Reset
REQ-014 RST SHALL asynchronously set the shift registers and PO to DEF_VALUE, UPD_STB to 0, ERR to 0, the counter to 0, and the UPDATE edge detector to 0.
REQ-015 RST asserted mid-shift SHALL abort the sequence; a following UPDATE without a new CAPTURE and full shift SHALL not commit when STRICT=1.

Verification
REQ-016 Defaults NREG=4, WIDTH=16: FSEL=0010, CAPTURE, shift 0xA5C3 LSB-first over 16 edges, UPDATE -> PO[31:16]=0xA5C3, UPD_STB=0010 for 1 cycle, other slices remain DEF_VALUE.
REQ-017 Chain mode: shift 64 bits 0x0123456789ABCDEF, UPDATE -> PO=0x0123456789ABCDEF, UPD_STB=1111.
REQ-018 STRICT=1, single mode, 15 shifts then UPDATE -> PO unchanged, ERR=1; a chain-mode CAPTURE with FSEL=0 -> ERR=0.
REQ-019 RDBK_SRC=1, RDBK slice 2=0xBEEF, FSEL=0100, CAPTURE, then 16 shifts -> TDO serialises 0xBEEF LSB-first (1,1,1,1,0,1,1,1,...).
REQ-020 FSEL=0110 during SHIFT -> no register changes, TDO=0, ERR=1; RST pulse mid-shift -> PO=DEF_VALUE and ERR=0 immediately.
